// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: 1..MAX_LEN-bit pattern, overlap select,
// Mealy match pulse, registered copy and saturating match counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic               y_q,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               cfg_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern, hist, w, mask;
  logic [LEN_W-1:0]   len, fill;
  logic               overlap, match, cfg_ok;

  assign w = {hist[MAX_LEN-2:0], din};

  // Only the low len bits of window and pattern take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++)
      mask[i] = (LEN_W'(i) < len);
  end

  assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign match  = din_valid & ~cfg_we & (fill >= len - LEN_W'(1)) &
                  (((w ^ pattern) & mask) == '0);
  assign y      = match & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern     <= MAX_LEN'(4'b1101);
      len         <= LEN_W'(4);
      overlap     <= 1'b1;
      hist        <= '0;
      fill        <= '0;
      y_q         <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      y_q     <= y;
      cfg_err <= 1'b0;
      if (cfg_we) begin
        // An illegal length leaves everything untouched and only flags the error.
        if (cfg_ok) begin
          pattern     <= cfg_pattern;
          len         <= cfg_len;
          overlap     <= cfg_overlap;
          hist        <= '0;
          fill        <= '0;
          match_count <= '0;
          count_sat   <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (din_valid) begin
        if (match && !overlap) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= w;
          if (fill != LEN_MAX) fill <= fill + LEN_W'(1);
        end
        if (match && match_count != CNT_MAX) begin
          match_count <= match_count + CNT_W'(1);
          if (match_count + CNT_W'(1) == CNT_MAX) count_sat <= 1'b1;
        end
      end
    end
  end

endmodule
